// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: queues received instructions and issues them one at a
// time to a datapath using a valid/ready offer, then waits for a bounded done strobe.
module spi_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  input  logic        cmd_ready,
  input  logic        cmd_done,
  input  logic        clr_err,
  output logic        cmd_valid,
  output logic [2:0]  cmd_op,
  output logic [3:0]  cmd_addr,
  output logic [7:0]  cmd_data,
  output logic        busy,
  output logic [4:0]  fifo_count,
  output logic        overflow,
  output logic        err_illegal,
  output logic        err_timeout
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_t;

  state_t      state_q;
  logic [15:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]  count_q, count_d;
  logic [7:0]  timer_q;
  logic        cmd_valid_q;
  logic [2:0]  cmd_op_q;
  logic [3:0]  cmd_addr_q;
  logic [7:0]  cmd_data_q;
  logic        overflow_q, overflow_d;
  logic        err_illegal_q, err_illegal_d;
  logic        err_timeout_q, err_timeout_d;

  logic        push, full_drop, pop;
  logic [15:0] head;
  logic        head_is_cmd, expire;

  always_comb begin
    push        = instr_valid && (count_q != 5'(FIFO_DEPTH));
    full_drop   = instr_valid && (count_q == 5'(FIFO_DEPTH));
    pop         = (state_q == IDLE) && (count_q != '0);
    head        = mem_q[rd_ptr_q];
    head_is_cmd = !head[15] && (head[14:12] != '0);
    expire      = (state_q == WAIT_DONE) && !cmd_done && (timer_q == 8'(TIMEOUT - 1));

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    // A set condition on the same edge as clr_err takes priority.
    overflow_d    = full_drop | (overflow_q & ~clr_err);
    err_illegal_d = (pop & head[15]) | (err_illegal_q & ~clr_err);
    err_timeout_d = expire | (err_timeout_q & ~clr_err);
  end

  always_ff @(posedge sclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= instr_in;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_op_q      <= '0;
      cmd_addr_q    <= '0;
      cmd_data_q    <= '0;
      overflow_q    <= 1'b0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end

      case (state_q)
        IDLE: begin
          if (pop && head_is_cmd) begin
            cmd_valid_q <= 1'b1;
            cmd_op_q    <= head[14:12];
            cmd_addr_q  <= head[11:8];
            cmd_data_q  <= head[7:0];
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            timer_q     <= '0;
            state_q     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (cmd_done || expire) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_op      = cmd_op_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_data    = cmd_data_q;
  assign fifo_count  = count_q;
  assign busy        = (state_q != IDLE) || (count_q != '0);
  assign overflow    = overflow_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;

endmodule
